// File: rtl/seq_pattern_tx.sv
`default_nettype none
// ============================================================================
// Module   : seq_pattern_tx
// Purpose  : Serial pattern transmitter. Captures an up-to-PAT_W-bit pattern
//            and shifts it out MSB-first, one bit per clock. The pattern is
//            repeated a programmable number of times, with GAP_CYCLES idle
//            cycles between repetitions. It drives the serial data input of
//            seq_det_101 for loopback, and serves as a stimulus source.
// Ports    : clock_in   - clock, all logic on posedge
//            rst_in     - synchronous reset, active-high
//            start_in   - start request, sampled only while idle
//            abort_in   - synchronous abort, any non-idle state
//            pattern_in - pattern, bits [len-1:0] used, bit len-1 sent first
//            len_in     - pattern length, values above PAT_W clamp to PAT_W
//            repeat_in  - number of transmissions, 0 treated as 1
//            data_out   - serial bit, 0 whenever valid_out is 0
//            valid_out  - data_out carries a pattern (or parity) bit
//            busy_out   - transfer in progress
//            done_out   - 1-cycle pulse after the last bit of the last frame
// Options  : SEQ_PATTERN_TX_PARITY_EN - append an even-parity bit to each frame
// Revision : 1.0 - initial release
// ============================================================================
module seq_pattern_tx #(
   parameter int PAT_W      = 8,
   parameter int LEN_W      = 4,
   parameter int RPT_W      = 4,
   parameter int GAP_CYCLES = 1
) (
   input  logic             clock_in,
   input  logic             rst_in,
   input  logic             start_in,
   input  logic             abort_in,
   input  logic [PAT_W-1:0] pattern_in,
   input  logic [LEN_W-1:0] len_in,
   input  logic [RPT_W-1:0] repeat_in,
   output logic             data_out,
   output logic             valid_out,
   output logic             busy_out,
   output logic             done_out
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SHIFT = 3'd1;
`ifdef SEQ_PATTERN_TX_PARITY_EN
   localparam logic [2:0] S_PAR   = 3'd2;
`endif
   localparam logic [2:0] S_GAP   = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GAP_W-1:0] c_GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [LEN_W-1:0] c_PAT_W_L  = LEN_W'(PAT_W);

   logic [2:0]       state_q, state_d;
   logic [PAT_W-1:0] pat_q,   pat_d;    // captured pattern, left-aligned
   logic [PAT_W-1:0] sh_q,    sh_d;     // remaining bits, next bit at MSB
   logic [LEN_W-1:0] len_q,   len_d;
   logic [LEN_W-1:0] cnt_q,   cnt_d;    // index of the bit currently on data_out
   logic [RPT_W-1:0] rpt_q,   rpt_d;    // repetitions left, including current
   logic [GAP_W-1:0] gap_q,   gap_d;
   logic             data_q,  data_d;
   logic             valid_q, valid_d;
   logic             busy_q,  busy_d;
   logic             done_q,  done_d;
`ifdef SEQ_PATTERN_TX_PARITY_EN
   logic             par_q,   par_d;    // XOR of bits sent so far in this frame
`endif

   logic [LEN_W-1:0] w_len;
   logic [PAT_W-1:0] w_aligned;
   logic [RPT_W-1:0] w_rpt;
   logic             w_frame_end;
   logic             w_reload;

   assign w_len     = (len_in > c_PAT_W_L) ? c_PAT_W_L : len_in;
   // Left-align so the first bit to send always sits at the MSB.
   assign w_aligned = pattern_in << (c_PAT_W_L - w_len);
   assign w_rpt     = (repeat_in == '0) ? RPT_W'(1) : repeat_in;

   always_comb begin
      state_d     = state_q;
      pat_d       = pat_q;
      sh_d        = sh_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      rpt_d       = rpt_q;
      gap_d       = gap_q;
      data_d      = 1'b0;
      valid_d     = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      w_frame_end = 1'b0;
      w_reload    = 1'b0;
`ifdef SEQ_PATTERN_TX_PARITY_EN
      par_d       = par_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (start_in && !abort_in) begin
               if (len_in == '0) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  pat_d   = w_aligned;
                  sh_d    = w_aligned << 1;
                  len_d   = w_len;
                  cnt_d   = w_len - LEN_W'(1);
                  rpt_d   = w_rpt;
                  state_d = S_SHIFT;
                  data_d  = w_aligned[PAT_W-1];
                  valid_d = 1'b1;
                  busy_d  = 1'b1;
`ifdef SEQ_PATTERN_TX_PARITY_EN
                  par_d   = w_aligned[PAT_W-1];
`endif
               end
            end
         end
         S_SHIFT: begin
            if (cnt_q != '0) begin
               cnt_d   = cnt_q - LEN_W'(1);
               sh_d    = sh_q << 1;
               data_d  = sh_q[PAT_W-1];
               valid_d = 1'b1;
               busy_d  = 1'b1;
`ifdef SEQ_PATTERN_TX_PARITY_EN
               par_d   = par_q ^ sh_q[PAT_W-1];
`endif
            end else begin
`ifdef SEQ_PATTERN_TX_PARITY_EN
               state_d = S_PAR;
               data_d  = par_q;
               valid_d = 1'b1;
               busy_d  = 1'b1;
`else
               w_frame_end = 1'b1;
`endif
            end
         end
`ifdef SEQ_PATTERN_TX_PARITY_EN
         S_PAR: begin
            w_frame_end = 1'b1;
         end
`endif
         S_GAP: begin
            busy_d = 1'b1;
            if (gap_q == c_GAP_LAST) begin
               w_reload = 1'b1;
            end else begin
               gap_d = gap_q + GAP_W'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Last cycle of a frame is on the output: pick gap, next frame or done.
      if (w_frame_end) begin
         if (rpt_q > RPT_W'(1)) begin
            rpt_d = rpt_q - RPT_W'(1);
            if (GAP_CYCLES > 0) begin
               state_d = S_GAP;
               gap_d   = '0;
               busy_d  = 1'b1;
            end else begin
               w_reload = 1'b1;
            end
         end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
         end
      end

      // Start the next repetition from the captured copy.
      if (w_reload) begin
         state_d = S_SHIFT;
         sh_d    = pat_q << 1;
         cnt_d   = len_q - LEN_W'(1);
         data_d  = pat_q[PAT_W-1];
         valid_d = 1'b1;
         busy_d  = 1'b1;
`ifdef SEQ_PATTERN_TX_PARITY_EN
         par_d   = pat_q[PAT_W-1];
`endif
      end

      if (abort_in && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
         data_d  = 1'b0;
         valid_d = 1'b0;
         busy_d  = 1'b0;
         done_d  = 1'b0;
      end
   end

   always_ff @(posedge clock_in) begin
      if (rst_in) begin
         state_q <= S_IDLE;
         pat_q   <= '0;
         sh_q    <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         rpt_q   <= '0;
         gap_q   <= '0;
         data_q  <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef SEQ_PATTERN_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         sh_q    <= sh_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         rpt_q   <= rpt_d;
         gap_q   <= gap_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef SEQ_PATTERN_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   assign data_out  = data_q;
   assign valid_out = valid_q;
   assign busy_out  = busy_q;
   assign done_out  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_pattern_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_pattern_tx
// Purpose  : Self-checking bench for seq_pattern_tx: a directed vector table,
//            hand-written corner sequences (abort, reset, start+abort) and
//            randomized transfers checked against a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_pattern_tx;

   localparam int PAT_W = 8;
   localparam int LEN_W = 4;
   localparam int RPT_W = 4;
   localparam int GAP   = 1;
`ifdef SEQ_PATTERN_TX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic             abort = 1'b0;
   logic [PAT_W-1:0] pat = '0;
   logic [LEN_W-1:0] len = '0;
   logic [RPT_W-1:0] rpt = '0;
   logic             data_o, valid_o, busy_o, done_o;

   int checks   = 0;
   int failures = 0;

   // Expected per-cycle outputs {valid, data, busy, done} after a start.
   logic [3:0] exp_q[$];

   typedef struct {
      logic [7:0] pat;
      int         len;
      int         rep;
      logic [7:0] frame;    // expected pattern bits, right-aligned
      int         flen;
      int         done_cyc; // done cycle without parity bits
      logic       par;      // even parity of the frame
      int         det;      // overlapping 101 count in the first frame
   } vec_t;

   vec_t tbl[7];

   seq_pattern_tx #(
      .PAT_W      (PAT_W),
      .LEN_W      (LEN_W),
      .RPT_W      (RPT_W),
      .GAP_CYCLES (GAP)
   ) dut (
      .clock_in   (clk),
      .rst_in     (rst),
      .start_in   (start),
      .abort_in   (abort),
      .pattern_in (pat),
      .len_in     (len),
      .repeat_in  (rpt),
      .data_out   (data_o),
      .valid_out  (valid_o),
      .busy_out   (busy_o),
      .done_out   (done_o)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] outs();
      return {valid_o, data_o, busy_o, done_o};
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Frame-level model: L bits MSB-first, optional parity, gaps between frames.
   task automatic build_model(input logic [7:0] p, input int l, input int r);
      int L;
      int R;
      L = (l > PAT_W) ? PAT_W : l;
      R = (r == 0) ? 1 : r;
      exp_q.delete();
      if (L != 0) begin
         for (int k = 0; k < R; k++) begin
            int par;
            par = 0;
            for (int i = L - 1; i >= 0; i--) begin
               exp_q.push_back({1'b1, p[i], 1'b1, 1'b0});
               par = par ^ int'(p[i]);
            end
            if (P != 0) exp_q.push_back({1'b1, par[0], 1'b1, 1'b0});
            if (k < R - 1) for (int g = 0; g < GAP; g++) exp_q.push_back(4'b0010);
         end
      end
      exp_q.push_back(4'b0001);
   endtask

   task automatic run_txn(input logic [7:0] p, input int l, input int r,
                          input int abort_at, input bit noisy, input string name);
      build_model(p, l, r);
      pat   = p;
      len   = l[3:0];
      rpt   = r[3:0];
      start = 1'b1;
      cyc();
      start = 1'b0;
      for (int i = 0; i < exp_q.size(); i++) begin
         check(name, 32'(outs()), 32'(exp_q[i]));
         if (noisy) begin
            pat   = 8'($urandom);
            len   = 4'($urandom);
            rpt   = 4'($urandom);
            start = 1'($urandom);
         end
         if (i == abort_at) begin
            abort = 1'b1;
            cyc();
            abort = 1'b0;
            start = 1'b0;
            check({name, "_abort"}, 32'(outs()), 32'd0);
            return;
         end
         cyc();
      end
      start = 1'b0;
      check({name, "_idle"}, 32'(outs()), 32'd0);
   endtask

   initial begin
      tbl[0] = '{8'b0000_0101, 3,  1, 8'b0000_0101, 3, 4,  1'b0, 1};
      tbl[1] = '{8'b0000_0101, 3,  2, 8'b0000_0101, 3, 8,  1'b0, 1};
      tbl[2] = '{8'b1011_0101, 8,  1, 8'b1011_0101, 8, 9,  1'b1, 3};
      tbl[3] = '{8'hA5,        12, 1, 8'hA5,        8, 9,  1'b0, 2};
      tbl[4] = '{8'hFF,        1,  0, 8'h01,        1, 2,  1'b1, 0};
      tbl[5] = '{8'h3C,        5,  3, 8'b0001_1100, 5, 18, 1'b1, 0};
      tbl[6] = '{8'h5A,        0,  2, 8'h00,        0, 1,  1'b0, 0};

      // Reset state
      cyc();
      cyc();
      check("reset_outs", 32'(outs()), 32'd0);
      rst = 1'b0;
      cyc();
      check("idle_outs", 32'(outs()), 32'd0);

      // Directed table
      for (int t = 0; t < 7; t++) begin
         logic got[$];
         int   dcyc;
         int   reff;
         int   fsz;
         int   det;
         string tn;
         tn    = $sformatf("tbl%0d", t);
         reff  = (tbl[t].rep == 0) ? 1 : tbl[t].rep;
         fsz   = tbl[t].flen + P;
         dcyc  = -1;
         got.delete();
         pat   = tbl[t].pat;
         len   = 4'(tbl[t].len);
         rpt   = 4'(tbl[t].rep);
         start = 1'b1;
         cyc();
         start = 1'b0;
         for (int c = 1; c <= 200; c++) begin
            if (valid_o) got.push_back(data_o);
            if (done_o) begin
               dcyc = c;
               break;
            end
            cyc();
         end
         check({tn, "_done_cycle"}, 32'(dcyc), 32'(tbl[t].done_cyc + P * reff));
         cyc();
         check({tn, "_after_done"}, 32'(outs()), 32'd0);
         check({tn, "_nbits"}, 32'(got.size()), 32'(reff * fsz));
         if (got.size() == reff * fsz && tbl[t].flen > 0) begin
            for (int r = 0; r < reff; r++) begin
               logic [7:0] fb;
               fb = '0;
               for (int j = 0; j < tbl[t].flen; j++) fb[tbl[t].flen - 1 - j] = got[r * fsz + j];
               check($sformatf("%s_frame%0d", tn, r), 32'(fb), 32'(tbl[t].frame));
               if (P != 0) check($sformatf("%s_par%0d", tn, r), 32'(got[r * fsz + tbl[t].flen]), 32'(tbl[t].par));
            end
            det = 0;
            for (int j = 0; j + 2 < tbl[t].flen; j++)
               if (got[j] && !got[j + 1] && got[j + 2]) det++;
            check({tn, "_det101"}, 32'(det), 32'(tbl[t].det));
         end
      end

      // Start and abort together in idle: abort wins
      pat   = 8'h05;
      len   = 4'd3;
      rpt   = 4'd1;
      start = 1'b1;
      abort = 1'b1;
      cyc();
      start = 1'b0;
      abort = 1'b0;
      check("start_abort_idle", 32'(outs()), 32'd0);
      cyc();
      check("start_abort_idle2", 32'(outs()), 32'd0);

      // Abort at 2nd bit of a len=8 transfer, then a normal restart
      run_txn(8'hB5, 8, 1, 1, 1'b0, "abort_2nd");
      run_txn(8'h5A, 8, 2, -1, 1'b0, "restart");

      // Inputs changing and start pulses while busy are ignored
      run_txn(8'hC6, 7, 3, -1, 1'b1, "noisy");

      // Reset mid-transfer
      pat   = 8'hFF;
      len   = 4'd8;
      rpt   = 4'd2;
      start = 1'b1;
      cyc();
      start = 1'b0;
      cyc();
      cyc();
      rst = 1'b1;
      cyc();
      check("reset_mid", 32'(outs()), 32'd0);
      rst = 1'b0;
      cyc();
      check("reset_mid_idle", 32'(outs()), 32'd0);

      // Randomized transfers against the model
      for (int n = 0; n < 40; n++) begin
         int ab;
         ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 30)) : -1;
         run_txn(8'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                 ab, 1'($urandom), $sformatf("rand%0d", n));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
